rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single cartridge ROM read port (rom_addr / rom_q / ce / oe / word) between two requesters.
- Port A is the CPU-side mapper fetch path; port B is a coprocessor fetch path (GSU/SA1/CX4 style).
- Port A has fixed priority. A starvation counter guarantees port B a slot.
- Drives the ROM port for a fixed read latency, captures rom_q, and returns data through a per-port req/ack handshake.

Parameters:
- ADDR_W, 24, ROM address width.
- LAT, 3, number of ACCESS cycles from driving the address to sampling rom_q; legal range 1..15.
- STARVE, 4, number of consecutive B losses after which B wins the next contested arbitration; legal range 1..15.

Ports:
- mclk  in  1  master clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- a_req  in  1  port A request; level, held until ack.
- a_addr  in  ADDR_W  port A byte address.
- a_word  in  1  port A 16-bit access flag.
- a_ack  out  1  port A one-cycle completion pulse.
- a_q  out  16  port A read data.
- b_req  in  1  port B request; level, held until ack.
- b_addr  in  ADDR_W  port B byte address.
- b_word  in  1  port B 16-bit access flag.
- b_ack  out  1  port B one-cycle completion pulse.
- b_q  out  16  port B read data.
- rom_addr  out  ADDR_W  ROM address.
- rom_ce_n  out  1  ROM chip enable, active low.
- rom_oe_n  out  1  ROM output enable, active low.
- rom_word  out  1  ROM 16-bit access.
- rom_q  in  16  ROM read data.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-access:
  - state=IDLE, cnt=0, starve=0, owner=A.
  - rom_addr=0, rom_word=0, rom_ce_n=1, rom_oe_n=1.
  - a_ack=b_ack=0, a_q=b_q=0, busy=0.
  - An in-flight access is dropped with no ack.
- State machine, IDLE -> ACCESS -> DONE -> IDLE:
  - IDLE: arbitrate on the current cycle's req values.
    - No req: stay in IDLE.
    - Only one req: grant that port.
    - Both req: grant B if starve >= STARVE, else grant A.
    - On grant: latch addr/word into rom_addr/rom_word, record owner, cnt=0, go to ACCESS.
  - ACCESS: rom_ce_n=0, rom_oe_n=0; rom_addr and rom_word are held stable.
    - cnt increments each cycle.
    - In the cycle where cnt==LAT-1, rom_q is registered into the owner's q register and the FSM goes to DONE.
    - ACCESS lasts exactly LAT cycles.
  - DONE: ce_n=oe_n=1; the owner's ack=1 for exactly one cycle; next state IDLE.
    - rom_addr and rom_word keep their last values.
- Timing:
  - req seen in IDLE at cycle t -> ack at cycle t+LAT+1, with q valid in that same cycle.
  - Back-to-back accesses from one port: issue rate is one per LAT+2 cycles.
- q registers:
  - A q register changes only when its own port is the owner.
  - It holds its value until that port's next completion.
  - rom_q is stored as all 16 bits regardless of word; byte selection belongs to the requester.
- Handshake:
  - The requester clears req at the edge where it samples ack=1, so req is low in the following IDLE cycle unless a new request is pending.
  - addr/word must stay stable from req assertion until ack.
  - req dropped before grant: no access is made.
  - req dropped after grant: the access completes and ack is still pulsed.
- Starvation counter (4 bits):
  - +1 when both req are high in IDLE and A is granted.
  - Cleared to 0 whenever B is granted.
  - Saturates at 15.
  - Unchanged by uncontested A grants.
- Simultaneous events:
  - Requests arriving during ACCESS/DONE wait; they are arbitrated in the next IDLE.
  - a_ack and b_ack are never high in the same cycle.
- Ports that are never asserted during an access:
  - rom_ce_n is high in IDLE and DONE.
  - Neither ack is high outside DONE.

Test Plan:
- Single A read, LAT=3: a_req at cycle 0, a_addr=0x123456, a_word=1, rom_q=0xBEEF during ACCESS.
  - rom_ce_n=0 in cycles 1-3 with rom_addr=0x123456.
  - a_ack=1 in cycle 4 only, a_q=0xBEEF; b_q stays 0.
- Contention without starvation: a_req and b_req both held.
  - A completes first; b_ack follows 5 cycles after a_ack (LAT+2).
  - starve=1 after the first contested A grant, then 0 after the B grant.
- Starvation, STARVE=4: a_req held continuously with new addresses, b_req held.
  - Exactly 4 A acks occur, then a b_ack, then A resumes.
- Reset mid-ACCESS: assert rst in the second ACCESS cycle.
  - Next cycle: rom_ce_n=1, busy=0, no ack ever issued, a_q=0.
  - A fresh a_req then completes normally with LAT+1 latency.
- Late drop: b_req pulsed for 1 cycle in IDLE with a_req low.
  - Full B access occurs; b_ack=1 at cycle LAT+1.
  - a_req raised during that B ACCESS is granted in the IDLE after DONE.
- LAT=1 boundary: single A read.
  - One ACCESS cycle, ack in cycle 2.
  - rom_q sampled in the cycle rom_ce_n=0.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the cartridge ROM read port: port A (CPU mapper) has fixed
// priority, port B (coprocessor) is guaranteed a slot by a starvation counter.
module rom_port_arbiter #(
    parameter int ADDR_W = 24,
    parameter int LAT    = 3,
    parameter int STARVE = 4
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_word,
    output logic              a_ack,
    output logic [15:0]       a_q,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_word,
    output logic              b_ack,
    output logic [15:0]       b_q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce_n,
    output logic              rom_oe_n,
    output logic              rom_word,
    input  logic [15:0]       rom_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LAT_LAST   = 4'(LAT - 1);
    localparam logic [3:0] STARVE_CNT = 4'(STARVE);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] starve;
    logic       owner;
    logic       grant_b;

    // B wins when alone, or when it has lost STARVE contested rounds in a row.
    assign grant_b = b_req && (!a_req || (starve >= STARVE_CNT));
    assign busy    = (state != IDLE);

    always_ff @(posedge mclk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            starve   <= 4'd0;
            owner    <= 1'b0;
            rom_addr <= '0;
            rom_word <= 1'b0;
            rom_ce_n <= 1'b1;
            rom_oe_n <= 1'b1;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        owner    <= grant_b;
                        rom_addr <= grant_b ? b_addr : a_addr;
                        rom_word <= grant_b ? b_word : a_word;
                        cnt      <= 4'd0;
                        rom_ce_n <= 1'b0;
                        rom_oe_n <= 1'b0;
                        state    <= ACCESS;
                        if (grant_b)
                            starve <= 4'd0;
                        else if (b_req && (starve != 4'd15))
                            starve <= starve + 4'd1;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    // Last access cycle: capture the ROM data and raise the owner's ack.
                    if (cnt == LAT_LAST) begin
                        if (owner)
                            b_q <= rom_q;
                        else
                            a_q <= rom_q;
                        a_ack    <= !owner;
                        b_ack    <= owner;
                        rom_ce_n <= 1'b1;
                        rom_oe_n <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: a LAT=3 instance for the main scenarios and a
// LAT=1 instance for the short-latency boundary.
module tb_rom_port_arbiter;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;

    logic        a_req = 1'b0, b_req = 1'b0, a_word = 1'b0, b_word = 1'b0;
    logic [23:0] a_addr = '0, b_addr = '0;
    logic        a_ack, b_ack, rom_ce_n, rom_oe_n, rom_word, busy;
    logic [15:0] a_q, b_q, rom_q;
    logic [23:0] rom_addr;

    logic        l_a_req = 1'b0, l_b_req = 1'b0, l_a_word = 1'b0, l_b_word = 1'b0;
    logic [23:0] l_a_addr = '0, l_b_addr = '0;
    logic        l_a_ack, l_b_ack, l_rom_ce_n, l_rom_oe_n, l_rom_word, l_busy;
    logic [15:0] l_a_q, l_b_q;
    logic [15:0] l_rom_q = 16'd0;
    logic [23:0] l_rom_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 mclk = ~mclk;

    // ROM model: data is a fixed scramble of the low address bits.
    assign rom_q = rom_addr[15:0] ^ 16'h8AB9;

    rom_port_arbiter #(.ADDR_W(24), .LAT(3), .STARVE(4)) dut (
        .mclk(mclk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_word(a_word), .a_ack(a_ack), .a_q(a_q),
        .b_req(b_req), .b_addr(b_addr), .b_word(b_word), .b_ack(b_ack), .b_q(b_q),
        .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
        .rom_word(rom_word), .rom_q(rom_q), .busy(busy)
    );

    rom_port_arbiter #(.ADDR_W(24), .LAT(1), .STARVE(4)) dut_lat1 (
        .mclk(mclk), .rst(rst),
        .a_req(l_a_req), .a_addr(l_a_addr), .a_word(l_a_word), .a_ack(l_a_ack), .a_q(l_a_q),
        .b_req(l_b_req), .b_addr(l_b_addr), .b_word(l_b_word), .b_ack(l_b_ack), .b_q(l_b_q),
        .rom_addr(l_rom_addr), .rom_ce_n(l_rom_ce_n), .rom_oe_n(l_rom_oe_n),
        .rom_word(l_rom_word), .rom_q(l_rom_q), .busy(l_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ar, input logic [23:0] aa, input logic aw,
                                 input logic br, input logic [23:0] ba, input logic bw);
        a_req = ar; a_addr = aa; a_word = aw;
        b_req = br; b_addr = ba; b_word = bw;
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        int a_cyc, b_cyc, n_acks, n_a_first, ack_count, both_hi;
        int a_ack_cyc[2];
        logic [5:0] order;

        // Reset
        rst = 1'b1;
        step();
        step();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ce_n", 32'(rom_ce_n), 32'd1);
        checkOutput("reset_oe_n", 32'(rom_oe_n), 32'd1);
        checkOutput("reset_acks", 32'({a_ack, b_ack}), 32'd0);
        checkOutput("reset_q", 32'({a_q, b_q}), 32'd0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        step();

        // Single A read
        applyStimulus(1'b1, 24'h123456, 1'b1, 1'b0, 24'h0, 1'b0);
        step();
        checkOutput("t1_c1_ce_n", 32'(rom_ce_n), 32'd0);
        checkOutput("t1_c1_oe_n", 32'(rom_oe_n), 32'd0);
        checkOutput("t1_c1_addr", 32'(rom_addr), 32'h123456);
        checkOutput("t1_c1_word", 32'(rom_word), 32'd1);
        checkOutput("t1_c1_busy", 32'(busy), 32'd1);
        step();
        checkOutput("t1_c2_ce_n", 32'(rom_ce_n), 32'd0);
        step();
        checkOutput("t1_c3_ce_n", 32'(rom_ce_n), 32'd0);
        checkOutput("t1_c3_ack", 32'(a_ack), 32'd0);
        step();
        checkOutput("t1_c4_ack", 32'(a_ack), 32'd1);
        checkOutput("t1_c4_a_q", 32'(a_q), 32'hBEEF);
        checkOutput("t1_c4_b_q", 32'(b_q), 32'd0);
        checkOutput("t1_c4_ce_n", 32'(rom_ce_n), 32'd1);
        checkOutput("t1_c4_addr_hold", 32'(rom_addr), 32'h123456);
        a_req = 1'b0;
        step();
        checkOutput("t1_c5_ack", 32'(a_ack), 32'd0);
        checkOutput("t1_c5_busy", 32'(busy), 32'd0);

        // Contention without starvation
        applyStimulus(1'b1, 24'h001000, 1'b0, 1'b1, 24'h200000, 1'b1);
        a_cyc = -1; b_cyc = -1; both_hi = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (a_ack && b_ack) both_hi++;
            if (a_ack) begin a_cyc = i; a_req = 1'b0; end
            if (b_ack) begin b_cyc = i; b_req = 1'b0; end
        end
        checkOutput("t2_a_ack_cyc", 32'(a_cyc), 32'd4);
        checkOutput("t2_b_ack_cyc", 32'(b_cyc), 32'd9);
        checkOutput("t2_a_q", 32'(a_q), 32'h9AB9);
        checkOutput("t2_b_q", 32'(b_q), 32'h8AB9);
        checkOutput("t2_both_ack", 32'(both_hi), 32'd0);

        // Starvation: A held with fresh addresses, B held
        applyStimulus(1'b1, 24'h000100, 1'b0, 1'b1, 24'h300010, 1'b0);
        order = '0; n_acks = 0; n_a_first = 0; both_hi = 0;
        a_ack_cyc[0] = -1; a_ack_cyc[1] = -1;
        for (int i = 1; i <= 60 && n_acks < 6; i++) begin
            step();
            if (a_ack && b_ack) both_hi++;
            if (a_ack) begin
                if (n_acks < 2) a_ack_cyc[n_acks] = i;
                if (order == '0) n_a_first++;
                n_acks++;
                a_addr = a_addr + 24'd2;
                if (n_acks == 6) a_req = 1'b0;
            end else if (b_ack) begin
                order[n_acks] = 1'b1;
                n_acks++;
                b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        checkOutput("t3_ack_count", 32'(n_acks), 32'd6);
        checkOutput("t3_ack_order", 32'(order), 32'b010000);
        checkOutput("t3_a_before_b", 32'(n_a_first), 32'd4);
        checkOutput("t3_first_a_cyc", 32'(a_ack_cyc[0]), 32'd4);
        checkOutput("t3_a_issue_rate", 32'(a_ack_cyc[1] - a_ack_cyc[0]), 32'd5);
        checkOutput("t3_b_q", 32'(b_q), 32'h8AA9);
        checkOutput("t3_a_q", 32'(a_q), 32'h8BB1);
        checkOutput("t3_both_ack", 32'(both_hi), 32'd0);
        step();
        step();

        // Reset in the second ACCESS cycle
        applyStimulus(1'b1, 24'h000ABC, 1'b0, 1'b0, 24'h0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        checkOutput("t4_ce_n", 32'(rom_ce_n), 32'd1);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_a_q", 32'(a_q), 32'd0);
        checkOutput("t4_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        a_req = 1'b0;
        ack_count = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_ack || b_ack) ack_count++;
        end
        checkOutput("t4_no_ack", 32'(ack_count), 32'd0);
        applyStimulus(1'b1, 24'h000ABC, 1'b0, 1'b0, 24'h0, 1'b0);
        a_cyc = -1;
        for (int i = 1; i <= 10 && a_cyc < 0; i++) begin
            step();
            if (a_ack) begin a_cyc = i; a_req = 1'b0; end
        end
        checkOutput("t4_fresh_ack_cyc", 32'(a_cyc), 32'd4);
        checkOutput("t4_fresh_a_q", 32'(a_q), 32'h8005);
        step();

        // Late drop of B, A raised during B's access
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 24'h300010, 1'b0);
        a_cyc = -1; b_cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) b_req = 1'b0;
            if (i == 2) begin a_req = 1'b1; a_addr = 24'h001000; end
            if (a_ack) begin a_cyc = i; a_req = 1'b0; end
            if (b_ack) b_cyc = i;
        end
        checkOutput("t5_b_ack_cyc", 32'(b_cyc), 32'd4);
        checkOutput("t5_b_q", 32'(b_q), 32'h8AA9);
        checkOutput("t5_a_ack_cyc", 32'(a_cyc), 32'd9);
        checkOutput("t5_a_q", 32'(a_q), 32'h9AB9);

        // LAT=1: one ACCESS cycle, data taken while ce_n is low
        l_a_req = 1'b1; l_a_addr = 24'h000055; l_a_word = 1'b0;
        step();
        checkOutput("t6_c1_ce_n", 32'(l_rom_ce_n), 32'd0);
        checkOutput("t6_c1_addr", 32'(l_rom_addr), 32'h000055);
        checkOutput("t6_c1_ack", 32'(l_a_ack), 32'd0);
        l_rom_q = 16'h1234;
        step();
        l_rom_q = 16'hFFFF;
        checkOutput("t6_c2_ack", 32'(l_a_ack), 32'd1);
        checkOutput("t6_c2_a_q", 32'(l_a_q), 32'h1234);
        checkOutput("t6_c2_ce_n", 32'(l_rom_ce_n), 32'd1);
        l_a_req = 1'b0;
        step();
        checkOutput("t6_c3_ack", 32'(l_a_ack), 32'd0);
        checkOutput("t6_c3_busy", 32'(l_busy), 32'd0);
        checkOutput("t6_c3_a_q_hold", 32'(l_a_q), 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
